// File: rtl/fft_pkg.sv
// Shared definitions for the FFT peak detector: widths, frame size and the
// packed complex sample layout produced by the 16-point FFT core.
package fft_pkg;
    localparam int OWIDTH  = 11;
    localparam int LGWIDTH = 4;
    localparam int MWIDTH  = 2 * OWIDTH;
    localparam int N       = 1 << LGWIDTH;

    localparam logic [LGWIDTH-1:0] DC_BIN   = '0;
    localparam logic [LGWIDTH-1:0] LAST_BIN = LGWIDTH'(N - 1);

    // {re, im}: real part in the upper half, imaginary in the lower half
    typedef struct packed {
        logic signed [OWIDTH-1:0] re;
        logic signed [OWIDTH-1:0] im;
    } cplx_t;
endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage |X|^2 pipeline: S1 squares both components, S2 sums them.
// Free-running; a valid bit and an opaque sideband ride alongside the data.
import fft_pkg::*;

module fft_mag_sq #(
    parameter int SBW = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  cplx_t             i_sample,
    input  logic [SBW-1:0]    i_side,
    output logic              o_valid,
    output logic [MWIDTH-1:0] o_mag,
    output logic [SBW-1:0]    o_side
);
    logic signed [MWIDTH-1:0] w_re_ext;
    logic signed [MWIDTH-1:0] w_im_ext;
    logic signed [MWIDTH-1:0] w_re_sq_full;
    logic signed [MWIDTH-1:0] w_im_sq_full;

    logic [MWIDTH-2:0] r_re_sq;
    logic [MWIDTH-2:0] r_im_sq;
    logic              r_v1;
    logic [SBW-1:0]    r_side1;

    // Sign-extend before multiplying so the product keeps full precision;
    // the largest square, (-2^(OWIDTH-1))^2, fits in MWIDTH-1 bits.
    assign w_re_ext     = MWIDTH'(i_sample.re);
    assign w_im_ext     = MWIDTH'(i_sample.im);
    assign w_re_sq_full = w_re_ext * w_re_ext;
    assign w_im_sq_full = w_im_ext * w_im_ext;

    // S1: register the two squares with their valid and sideband
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_re_sq <= '0;
            r_im_sq <= '0;
            r_v1    <= 1'b0;
            r_side1 <= '0;
        end else begin
            r_re_sq <= w_re_sq_full[MWIDTH-2:0];
            r_im_sq <= w_im_sq_full[MWIDTH-2:0];
            r_v1    <= i_valid;
            r_side1 <= i_side;
        end
    end

    // S2: sum of squares, one extra bit so the add cannot overflow
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mag   <= '0;
            o_valid <= 1'b0;
            o_side  <= '0;
        end else begin
            o_mag   <= {1'b0, r_re_sq} + {1'b0, r_im_sq};
            o_valid <= r_v1;
            o_side  <= r_side1;
        end
    end
endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak finder for the FFT output stream. Tracks the bin position,
// feeds |X|^2 through fft_mag_sq, keeps the running maximum and publishes the
// peak bin/magnitude once per frame.
// Build option FFT_PEAK_SKIP_DC_EN: exclude bin 0 from the peak search.
import fft_pkg::*;

module fft_peak_detect (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic [2*OWIDTH-1:0]   i_result,
    input  logic                  i_sync,
    output logic                  o_valid,
    output logic [LGWIDTH-1:0]    o_bin,
    output logic [MWIDTH-1:0]     o_mag,
    output logic                  o_sync_err
);
    // Handshake: there is no back-pressure. A sample is taken on every edge
    // where i_ce is high and the block is armed (or i_sync arms it); o_valid
    // and o_sync_err are single-cycle strobes, o_bin/o_mag hold until the
    // next o_valid.

    // Sideband layout: {err, first, last, bin}
    localparam int SBW = LGWIDTH + 3;

    logic               r_armed;
    logic [LGWIDTH-1:0] r_bin;

    logic               w_restart;
    logic               w_accept;
    logic               w_err;
    logic [LGWIDTH-1:0] w_bin;

    logic               r_s0_valid;
    cplx_t              r_s0_sample;
    logic [SBW-1:0]     r_s0_side;

    logic               w_s2_valid;
    logic [MWIDTH-1:0]  w_s2_mag;
    logic [SBW-1:0]     w_s2_side;
    logic               w_s2_err;
    logic               w_s2_first;
    logic               w_s2_last;
    logic [LGWIDTH-1:0] w_s2_bin;

    logic [MWIDTH-1:0]  r_best_mag;
    logic [LGWIDTH-1:0] r_best_bin;
    logic [MWIDTH-1:0]  w_new_mag;
    logic [LGWIDTH-1:0] w_new_bin;

    // A sync while armed is only legitimate right after bin N-1; anywhere
    // else it aborts the partial frame and restarts at bin 0.
    assign w_restart = i_ce & i_sync;
    assign w_accept  = i_ce & (r_armed | i_sync);
    assign w_err     = w_restart & r_armed & (r_bin != LAST_BIN);
    assign w_bin     = w_restart ? DC_BIN : r_bin + 1'b1;

    // Frame position counter; the increment wraps N-1 -> 0 on its own
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_armed <= 1'b0;
            r_bin   <= '0;
        end else if (w_accept) begin
            r_armed <= 1'b1;
            r_bin   <= w_bin;
        end
    end

    // Input capture: the accepting edge registers the sample and its tags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s0_valid  <= 1'b0;
            r_s0_sample <= '0;
            r_s0_side   <= '0;
        end else begin
            r_s0_valid  <= w_accept;
            r_s0_sample <= i_result;
            r_s0_side   <= {w_err, w_bin == DC_BIN, w_bin == LAST_BIN, w_bin};
        end
    end

    fft_mag_sq #(
        .SBW (SBW)
    ) u_mag_sq (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (r_s0_valid),
        .i_sample (r_s0_sample),
        .i_side   (r_s0_side),
        .o_valid  (w_s2_valid),
        .o_mag    (w_s2_mag),
        .o_side   (w_s2_side)
    );

    assign w_s2_err   = w_s2_side[SBW-1];
    assign w_s2_first = w_s2_side[SBW-2];
    assign w_s2_last  = w_s2_side[SBW-3];
    assign w_s2_bin   = w_s2_side[LGWIDTH-1:0];

    // Post-update best: first bin reseeds, later bins replace only if strictly larger
    always_comb begin
        w_new_mag = r_best_mag;
        w_new_bin = r_best_bin;
        if (w_s2_first) begin
`ifdef FFT_PEAK_SKIP_DC_EN
            w_new_mag = '0;
            w_new_bin = LGWIDTH'(1);
`else
            w_new_mag = w_s2_mag;
            w_new_bin = w_s2_bin;
`endif
        end else if (w_s2_mag > r_best_mag) begin
            w_new_mag = w_s2_mag;
            w_new_bin = w_s2_bin;
        end
    end

    // S3: commit running best and publish on the last bin of a frame
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_best_mag <= '0;
            r_best_bin <= '0;
            o_valid    <= 1'b0;
            o_sync_err <= 1'b0;
            o_bin      <= '0;
            o_mag      <= '0;
        end else begin
            o_valid    <= w_s2_valid & w_s2_last;
            o_sync_err <= w_s2_valid & w_s2_err;
            if (w_s2_valid) begin
                r_best_mag <= w_new_mag;
                r_best_bin <= w_new_bin;
            end
            if (w_s2_valid & w_s2_last) begin
                o_bin <= w_new_bin;
                o_mag <= w_new_mag;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_detect.sv
// Randomized bench for fft_peak_detect with a frame-level reference model.
// Define FFT_PEAK_SKIP_DC_EN for both bench and RTL to cover the DC-skip build.
module tb_fft_peak_detect;
    import fft_pkg::*;

    localparam int K_RESET = 0;
    localparam int K_VALID = 1;
    localparam int K_ERR   = 2;

    typedef struct packed {
        logic [31:0]        edge_no;
        logic [1:0]         kind;
        logic [LGWIDTH-1:0] bin;
        logic [MWIDTH-1:0]  mag;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic                i_clk    = 1'b0;
    logic                i_reset  = 1'b1;
    logic                i_ce     = 1'b0;
    logic                i_sync   = 1'b0;
    logic [2*OWIDTH-1:0] i_result = '0;
    logic                o_valid;
    logic [LGWIDTH-1:0]  o_bin;
    logic [MWIDTH-1:0]   o_mag;
    logic                o_sync_err;

    always #5 i_clk = ~i_clk;

    int edge_cnt = 0;
    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    fft_peak_detect dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_result   (i_result),
        .i_sync     (i_sync),
        .o_valid    (o_valid),
        .o_bin      (o_bin),
        .o_mag      (o_mag),
        .o_sync_err (o_sync_err)
    );

    // ---------------- scoreboard state ----------------
    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    bit   m_armed = 1'b0;
    int   m_pos   = 0;
    int   m_mag[N];
    int   fr_re[N];
    int   fr_im[N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, want, edge_cnt);
    endtask

    function automatic int rnd_full();
        return int'($urandom_range(2047, 0)) - 1024;
    endfunction

    function automatic int rnd_small(input int lim);
        return int'($urandom_range(2 * lim, 0)) - lim;
    endfunction

    // Reference: peak of a completed frame from its N magnitudes
    task automatic push_peak(input int tgt);
        exp_t e;
        int   bb;
        int   bm;
`ifdef FFT_PEAK_SKIP_DC_EN
        bb = 1;
        bm = 0;
`else
        bb = 0;
        bm = m_mag[0];
`endif
        for (int k = 1; k < N; k++) begin
            if (m_mag[k] > bm) begin
                bm = m_mag[k];
                bb = k;
            end
        end
        e.edge_no = tgt;
        e.kind    = 2'(K_VALID);
        e.bin     = LGWIDTH'(bb);
        e.mag     = MWIDTH'(bm);
        exp_q.push_back(e);
    endtask

    task automatic push_event(input int tgt, input int kind);
        exp_t e;
        e.edge_no = tgt;
        e.kind    = 2'(kind);
        e.bin     = '0;
        e.mag     = '0;
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    // Drives one clock worth of inputs and applies the frame rules to the model
    task automatic step(input bit ce, input bit sync, input int re, input int im, input bit rst);
        int tgt;
        i_ce     = ce;
        i_sync   = sync;
        i_reset  = rst;
        i_result = {re[OWIDTH-1:0], im[OWIDTH-1:0]};
        tgt      = edge_cnt + 1;
        if (rst) begin
            exp_q.delete();
            push_event(tgt, K_RESET);
            m_armed = 1'b0;
            m_pos   = 0;
        end else if (ce && (m_armed || sync)) begin
            if (sync) begin
                if (m_armed && m_pos != N - 1) push_event(tgt + 3, K_ERR);
                m_pos   = 0;
                m_armed = 1'b1;
            end else begin
                m_pos = (m_pos + 1) % N;
            end
            m_mag[m_pos] = re * re + im * im;
            if (m_pos == N - 1) push_peak(tgt + 3);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, bit'($urandom_range(1, 0)), rnd_full(), rnd_full(), 1'b0);
    endtask

    task automatic fill(input int lim);
        for (int k = 0; k < N; k++) begin
            fr_re[k] = (lim == 0) ? 0 : rnd_small(lim);
            fr_im[k] = (lim == 0) ? 0 : rnd_small(lim);
        end
    endtask

    task automatic send_frame(input int gap_lo, input int gap_hi, input bit with_sync, input int nbins);
        for (int b = 0; b < nbins; b++) begin
            int g;
            g = int'($urandom_range(gap_hi, gap_lo));
            idle(g);
            step(1'b1, with_sync && (b == 0), fr_re[b], fr_im[b], 1'b0);
        end
    endtask

    // ---------------- monitor (negedge, away from the active edge) ----------------
    exp_t               mon_e;
    logic               mon_v;
    logic               mon_err;
    logic [LGWIDTH-1:0] held_bin = '0;
    logic [MWIDTH-1:0]  held_mag = '0;

    always @(negedge i_clk) begin
        if (edge_cnt > 0) begin
            mon_v   = 1'b0;
            mon_err = 1'b0;
            if (exp_q.size() > 0 && int'(exp_q[0].edge_no) == edge_cnt) begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind == 2'(K_RESET)) begin
                    held_bin = '0;
                    held_mag = '0;
                end else if (mon_e.kind == 2'(K_VALID)) begin
                    mon_v    = 1'b1;
                    held_bin = mon_e.bin;
                    held_mag = mon_e.mag;
                end else begin
                    mon_err = 1'b1;
                end
            end
            check("o_valid", 64'(o_valid), 64'(mon_v));
            check("o_sync_err", 64'(o_sync_err), 64'(mon_err));
            check("o_bin", 64'(o_bin), 64'(held_bin));
            check("o_mag", 64'(o_mag), 64'(held_mag));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < N; k++) m_mag[k] = 0;

        step(1'b0, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        idle(2);

        // Unarmed: samples without sync are ignored
        repeat (6) step(1'b1, 1'b0, rnd_full(), rnd_full(), 1'b0);

        // Single peak at bin 5: 100^2 + 50^2 = 12500
        fill(0);
        fr_re[5] = 100;
        fr_im[5] = -50;
        send_frame(0, 0, 1'b1, N);
        idle(6);

        // Tie between bins 3 and 9 at the most negative value
        fill(0);
        fr_re[3] = -1024;
        fr_re[9] = -1024;
        send_frame(0, 0, 1'b1, N);
        idle(6);

        // Back-to-back frames, continuous i_ce
        fill(20);
        fr_re[2] = 700;
        send_frame(0, 0, 1'b1, N);
        fill(20);
        fr_im[14] = -900;
        send_frame(0, 0, 1'b1, N);
        idle(6);

        // Early sync at bin 7 aborts the frame, the restart frame reports
        fill(20);
        fr_re[4] = 600;
        send_frame(0, 0, 1'b1, 7);
        fill(20);
        fr_im[11] = 300;
        send_frame(0, 0, 1'b1, N);
        fill(20);
        fr_re[8] = -250;
        send_frame(0, 0, 1'b1, N);
        idle(6);

        // Strong DC bin with 1-3 cycle gaps
        fill(20);
        fr_re[0] = 500;
        fr_im[6] = 90;
        send_frame(1, 3, 1'b1, N);
        idle(6);

        // Reset at bin 10, then unsynced samples are ignored
        fill(20);
        fr_re[12] = 400;
        send_frame(0, 0, 1'b1, 10);
        step(1'b1, 1'b0, rnd_full(), rnd_full(), 1'b1);
        repeat (8) step(1'b1, 1'b0, rnd_full(), rnd_full(), 1'b0);
        fill(20);
        fr_re[7] = 333;
        send_frame(0, 0, 1'b1, N);
        idle(6);

        // Random frames: full-range or tiny values (ties), gaps, missing syncs
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(1, 0) == 1) begin
                for (int k = 0; k < N; k++) begin
                    fr_re[k] = rnd_full();
                    fr_im[k] = rnd_full();
                end
            end else begin
                fill(2);
            end
            send_frame(0, 2, bit'($urandom_range(3, 0) != 0), N);
        end
        idle(8);

        check("drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
